// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
// ---------------------------------------------------------------------------
// Initiator side of a 32-bit combinational ALU interface. Commands (opcode plus
// two operands) arrive on a valid/ready handshake and wait in a small FIFO.
// The head entry drives the external ALU directly from storage registers. Each
// ALU result is captured into a result register that has its own valid/ready
// handshake. Together these turn the combinational ALU into a flow-controlled
// stage that executes one operation per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   cmd_valid  command present          cmd_ready  FIFO can accept this cycle
//   cmd_op     ALU opcode               cmd_a/b    operands A and B
//   alu_A/B    operands to the ALU      alu_op     opcode to the ALU
//   alu_C      combinational ALU result
//   res_valid  result register holds an unconsumed result
//   res_ready  consumer takes the result this cycle
//   res_data   registered ALU result    res_op     opcode that produced it
//   count      FIFO occupancy
//   err        sticky flag, set when an illegal opcode (110/111) executes
// ---------------------------------------------------------------------------
module alu_cmd_issuer #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [2:0]                 cmd_op,
   input  logic [W-1:0]               cmd_a,
   input  logic [W-1:0]               cmd_b,
   output logic [W-1:0]               alu_A,
   output logic [W-1:0]               alu_B,
   output logic [2:0]                 alu_op,
   input  logic [W-1:0]               alu_C,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [W-1:0]               res_data,
   output logic [2:0]                 res_op,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [2:0]    opMem [DEPTH];
   logic [W-1:0]  aMem  [DEPTH];
   logic [W-1:0]  bMem  [DEPTH];
   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;

   logic          push;
   logic          issue;
   logic          notEmpty;
   logic [2:0]    headOp;

   // Handshake decode. cmd_ready depends on occupancy alone, with no bypass,
   // so a push into a full FIFO never happens even when a pop occurs in the
   // same cycle. An issue needs a queued command and a result register that is
   // either empty or being drained in this same cycle.
   assign notEmpty  = (count != '0);
   assign cmd_ready = (count != CW'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign issue     = notEmpty && (!res_valid || res_ready);
   assign headOp    = opMem[rdPtr];

   // The ALU is driven straight from the head storage registers, which keeps
   // its inputs glitch-free. When the FIFO is empty, zeros are presented so the
   // ALU sees a defined, quiet input.
   assign alu_A  = notEmpty ? aMem[rdPtr] : '0;
   assign alu_B  = notEmpty ? bMem[rdPtr] : '0;
   assign alu_op = notEmpty ? headOp      : 3'b000;

   // Command storage. A write only happens on an accepted push. The storage is
   // cleared on reset so the head registers start out in a known state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            opMem[i] <= 3'b000;
            aMem[i]  <= '0;
            bMem[i]  <= '0;
         end
      end else if (push) begin
         opMem[wrPtr] <= cmd_op;
         aMem[wrPtr]  <= cmd_a;
         bMem[wrPtr]  <= cmd_b;
      end
   end

   // Pointers and occupancy. The pointers are log2(DEPTH) bits wide and wrap
   // naturally. Full and empty are told apart by count, never by comparing
   // the pointers. A simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + PW'(1);
         end
         if (issue) begin
            rdPtr <= rdPtr + PW'(1);
         end
         case ({push, issue})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Result register. An issue captures the ALU output together with the
   // opcode that produced it. If the result is consumed and no new issue
   // replaces it, only the valid flag drops; the data and opcode hold their
   // last values. err is sticky and is cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_op    <= 3'b000;
         err       <= 1'b0;
      end else begin
         if (issue) begin
            res_valid <= 1'b1;
            res_data  <= alu_C;
            res_op    <= headOp;
            if (headOp[2:1] == 2'b11) begin
               err <= 1'b1;
            end
         end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer
// ---------------------------------------------------------------------------
// Self-checking bench for alu_cmd_issuer. It plays the role of the external
// combinational ALU. A reference model tracks the queue of pending commands
// and the result register, and the bench compares every DUT output against
// that model after each clock edge.
// ---------------------------------------------------------------------------
module tb_alu_cmd_issuer;

   localparam int DEPTH = 4;
   localparam int W     = 32;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } cmd_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic [31:0] alu_A;
   logic [31:0] alu_B;
   logic [2:0]  alu_op;
   logic [31:0] alu_C;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [2:0]  res_op;
   logic [2:0]  count;
   logic        err;

   int total = 0;
   int bad   = 0;

   cmd_t        cmdQ[$];
   logic        mResValid;
   logic [31:0] mResData;
   logic [2:0]  mResOp;
   logic        mErr;
   int          maxSeen;

   alu_cmd_issuer #(.DEPTH(DEPTH), .W(W)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_C(alu_C),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_op(res_op),
      .count(count), .err(err)
   );

   always #5 clk = ~clk;

   // The ALU behaviour that the issuer depends on.
   function automatic logic [31:0] aluRef(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         3'b100:  return a >> b;
         3'b101:  return 32'($signed(a) >>> b);
         default: return 32'h0;
      endcase
   endfunction

   // External combinational ALU.
   always_comb begin
      alu_C = aluRef(alu_op, alu_A, alu_B);
   end

   // Single comparison: counts it and reports a mismatch.
   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compares the full visible DUT state against the reference model.
   task automatic checkOutput(input string tag);
      cmd_t h;
      checkVal({tag, ":count"}, 32'(count), 32'(cmdQ.size()));
      checkVal({tag, ":res_valid"}, 32'(res_valid), 32'(mResValid));
      checkVal({tag, ":res_data"}, res_data, mResData);
      checkVal({tag, ":res_op"}, 32'(res_op), 32'(mResOp));
      checkVal({tag, ":err"}, 32'(err), 32'(mErr));
      checkVal({tag, ":cmd_ready"}, 32'(cmd_ready), 32'(cmdQ.size() != DEPTH));
      if (cmdQ.size() != 0) begin
         h = cmdQ[0];
      end else begin
         h.op = 3'b000;
         h.a  = 32'h0;
         h.b  = 32'h0;
      end
      checkVal({tag, ":alu_op"}, 32'(alu_op), 32'(h.op));
      checkVal({tag, ":alu_A"}, alu_A, h.a);
      checkVal({tag, ":alu_B"}, alu_B, h.b);
      if (32'(count) > maxSeen) begin
         maxSeen = 32'(count);
      end
   endtask

   // Drives one cycle of inputs, advances the model across the clock edge and
   // then checks the outputs. The task is entered just after a rising edge.
   task automatic applyStimulus(input string tag, input logic v, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic rr, output logic accepted);
      cmd_t c;
      logic issue;
      cmd_valid = v;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      res_ready = rr;
      accepted  = v && (cmdQ.size() != DEPTH);
      issue     = (cmdQ.size() != 0) && (!mResValid || rr);
      @(posedge clk);
      if (issue) begin
         c         = cmdQ.pop_front();
         mResData  = aluRef(c.op, c.a, c.b);
         mResOp    = c.op;
         mResValid = 1'b1;
         if (c.op >= 3'd6) begin
            mErr = 1'b1;
         end
      end else if (mResValid && rr) begin
         mResValid = 1'b0;
      end
      if (accepted) begin
         c.op = op;
         c.a  = a;
         c.b  = b;
         cmdQ.push_back(c);
      end
      #1;
      checkOutput(tag);
      cmd_valid = 1'b0;
   endtask

   task automatic clearModel();
      cmdQ.delete();
      mResValid = 1'b0;
      mResData  = 32'h0;
      mResOp    = 3'b000;
      mErr      = 1'b0;
   endtask

   initial begin
      logic acc;
      int   sent;
      int   cyc;
      clearModel();
      maxSeen   = 0;
      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'b000;
      cmd_a     = 32'h0;
      cmd_b     = 32'h0;
      res_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset");

      // Single add: result visible one edge after acceptance, then consumed.
      applyStimulus("add_push", 1'b1, 3'b000, 32'd5, 32'd7, 1'b1, acc);
      checkVal("add_not_yet_valid", 32'(res_valid), 32'd0);
      applyStimulus("add_res", 1'b0, 3'b000, 32'd0, 32'd0, 1'b1, acc);
      checkVal("add_data", res_data, 32'd12);
      applyStimulus("add_drained", 1'b0, 3'b000, 32'd0, 32'd0, 1'b1, acc);
      checkVal("add_valid_low", 32'(res_valid), 32'd0);

      // Back-to-back commands with the consumer always ready.
      maxSeen = 0;
      applyStimulus("b2b_sub", 1'b1, 3'b001, 32'd3, 32'd5, 1'b1, acc);
      applyStimulus("b2b_and", 1'b1, 3'b010, 32'hF0F0, 32'h0FF0, 1'b1, acc);
      checkVal("b2b_sub_data", res_data, 32'hFFFF_FFFE);
      applyStimulus("b2b_or", 1'b1, 3'b011, 32'h1, 32'h2, 1'b1, acc);
      checkVal("b2b_and_data", res_data, 32'h0000_00F0);
      applyStimulus("b2b_srl", 1'b1, 3'b100, 32'h8000_0000, 32'd4, 1'b1, acc);
      checkVal("b2b_or_data", res_data, 32'h3);
      applyStimulus("b2b_tail", 1'b0, 3'b000, 32'd0, 32'd0, 1'b1, acc);
      checkVal("b2b_srl_data", res_data, 32'h0800_0000);
      applyStimulus("b2b_idle", 1'b0, 3'b000, 32'd0, 32'd0, 1'b1, acc);
      checkVal("b2b_maxcount", 32'(maxSeen), 32'd1);

      // Backpressure: five commands fill the result register plus the FIFO.
      for (int i = 0; i < 5; i++) begin
         applyStimulus("bp_push", 1'b1, 3'b000, 32'(100 + i), 32'(i), 1'b0, acc);
      end
      checkVal("bp_count_full", 32'(count), 32'(DEPTH));
      checkVal("bp_ready_low", 32'(cmd_ready), 32'd0);
      applyStimulus("bp_held", 1'b1, 3'b001, 32'd50, 32'd8, 1'b0, acc);
      checkVal("bp_held_rejected", 32'(acc), 32'd0);
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         applyStimulus("bp_drain_held", 1'b1, 3'b001, 32'd50, 32'd8, 1'b1, acc);
      end
      checkVal("bp_held_accepted", 32'(acc), 32'd1);
      for (int i = 0; i < 8; i++) begin
         applyStimulus("bp_drain", 1'b0, 3'b000, 32'd0, 32'd0, 1'b1, acc);
      end
      checkVal("bp_empty", 32'(count), 32'd0);

      // Arithmetic shift followed by an illegal opcode.
      applyStimulus("sra_push", 1'b1, 3'b101, 32'h8000_0000, 32'd4, 1'b1, acc);
      applyStimulus("ill_push", 1'b1, 3'b111, 32'd9, 32'd9, 1'b1, acc);
      checkVal("sra_data", res_data, 32'hF800_0000);
      checkVal("err_before_ill", 32'(err), 32'd0);
      applyStimulus("ill_res", 1'b0, 3'b000, 32'd0, 32'd0, 1'b1, acc);
      checkVal("ill_data", res_data, 32'h0);
      checkVal("ill_op", 32'(res_op), 32'd7);
      checkVal("ill_err", 32'(err), 32'd1);
      applyStimulus("ill_sticky", 1'b0, 3'b000, 32'd0, 32'd0, 1'b1, acc);
      checkVal("err_sticky", 32'(err), 32'd1);

      // Asynchronous reset mid-stream, with three commands queued behind a
      // pending result.
      for (int i = 0; i < 4; i++) begin
         applyStimulus("rst_fill", 1'b1, 3'b011, 32'(i), 32'h10, 1'b0, acc);
      end
      checkVal("rst_pre_count", 32'(count), 32'd3);
      #2;
      reset = 1'b0;
      #1;
      checkVal("rst_async_count", 32'(count), 32'd0);
      checkVal("rst_async_valid", 32'(res_valid), 32'd0);
      checkVal("rst_async_ready", 32'(cmd_ready), 32'd1);
      checkVal("rst_async_aluop", 32'(alu_op), 32'd0);
      checkVal("rst_async_err", 32'(err), 32'd0);
      clearModel();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_release");

      // Random stream long enough to wrap the pointers several times.
      sent = 0;
      cyc  = 0;
      while (sent < 3 * DEPTH && cyc < 2000) begin
         logic [31:0] b;
         b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
         applyStimulus("rnd", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                       $urandom, b, ($urandom_range(0, 2) != 0), acc);
         checkVal("rnd_count_bound", 32'(count <= DEPTH), 32'd1);
         if (acc) begin
            sent++;
         end
         cyc++;
      end
      checkVal("rnd_all_sent", 32'(sent), 32'(3 * DEPTH));
      cyc = 0;
      while ((cmdQ.size() != 0 || mResValid) && cyc < 50) begin
         applyStimulus("rnd_drain", 1'b0, 3'b000, 32'd0, 32'd0, 1'b1, acc);
         cyc++;
      end
      checkVal("rnd_final_count", 32'(count), 32'd0);
      checkVal("rnd_final_valid", 32'(res_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the 32-bit ALU operand/result interface (A, B, ALUOp in; C out).
- Buffers operation commands arriving on a valid/ready handshake in a small FIFO.
- Drives the head command onto the external combinational ALU and registers C into a result register with its own valid/ready handshake.
- Turns the purely combinational ALU into a flow-controlled, one-op-per-cycle execution stage.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- W, 32, operand/result width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept the command this cycle.
- cmd_op  in  3  ALU opcode.
- cmd_a  in  W  operand A.
- cmd_b  in  W  operand B.
- alu_A  out  W  to ALU A.
- alu_B  out  W  to ALU B.
- alu_op  out  3  to ALU ALUOp.
- alu_C  in  W  from ALU C (combinational on alu_A/alu_B/alu_op).
- res_valid  out  1  result register holds an unconsumed result.
- res_ready  in  1  consumer takes the result this cycle.
- res_data  out  W  registered ALU result.
- res_op  out  3  opcode that produced res_data.
- count  out  clog2(DEPTH+1)  FIFO occupancy.
- err  out  1  sticky: an illegal opcode (110 or 111) was executed.

Behaviour:
- Reset (reset=0): FIFO empty, count=0, res_valid=0, res_data=0, res_op=0, err=0, alu_A=alu_B=0, alu_op=000. Takes effect asynchronously, including mid-operation: all in-flight commands and any pending result are discarded.
- ALU encoding the block relies on: 000 add, 001 sub (wraparound mod 2^W), 010 and, 011 or, 100 logical right shift A>>B, 101 arithmetic right shift, others give 0.
- Push: accepted when cmd_valid && cmd_ready; cmd_ready = (count != DEPTH). A command offered while full is not accepted; the source must hold it.
- ALU drive: the head entry drives alu_A/alu_B/alu_op straight from FIFO storage registers, so the ALU inputs are glitch-free. When the FIFO is empty, these outputs are 0/0/000.
- Issue condition: issue = (count != 0) && (!res_valid || res_ready).
- On issue, at the clock edge:
  - res_data <= alu_C, res_op <= head op, res_valid <= 1, head popped.
  - If the head op is 110 or 111, err <= 1.
- Result consumed without a new issue: res_valid && res_ready && count==0 -> res_valid <= 0; res_data and res_op hold their values.
- Simultaneous push and pop: count unchanged, pointers both advance. Push into a full FIFO with a simultaneous pop is not allowed, because cmd_ready depends only on count (no bypass).
- Latency: a command accepted at edge N with the FIFO empty and no result stall has res_valid=1 with its result after edge N+1. Steady-state throughput is one op per cycle while res_ready=1.
- Ordering: results are strictly in command order; no reordering, no drop.
- Read/write pointers are log2(DEPTH) bits and wrap naturally. Full/empty are distinguished by count, never by pointer equality.
- err clears only on reset.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-stream with 3 commands queued -> count=0, res_valid=0, cmd_ready=1, alu_op=000, err=0 immediately (asynchronously).
- Single add: push op=000, A=5, B=7 at edge N with res_ready=1 -> after edge N+1: res_valid=1, res_data=12, res_op=000; after edge N+2: res_valid=0.
- Back-to-back with res_ready=1: push sub 3-5, and 0xF0F0&0x0FF0, or 0x1|0x2, srl 0x80000000>>4 on consecutive cycles -> results 0xFFFFFFFE, 0x00F0, 0x3, 0x08000000 on consecutive cycles, count never above 1.
- Backpressure with res_ready=0: push 5 commands -> first lands in the result register, count reaches 4, cmd_ready=0. A 6th command is held and not lost. Raising res_ready drains all 5 in order, one per cycle.
- SRA and illegal op: push op=101, A=0x80000000, B=4, then op=111, A=9, B=9 -> res_data 0xF8000000, then 0 with res_op=111. err rises at that edge and stays 1 afterwards.
- Wrap-around: stream 3*DEPTH commands with random res_ready -> every result matches the reference model in order, and count stays within 0..DEPTH throughout.
